// File: rtl/vga_tile_engine.sv
// Parametrised VGA tile engine: timing counters, board RAM fetch, palette lookup and
// sync/RGB outputs aligned through a two-pixel-slot pipeline.
module vga_tile_engine #(
    parameter int                 H_ACTIVE   = 640,
    parameter int                 H_FP       = 16,
    parameter int                 H_SYNC     = 96,
    parameter int                 H_BP       = 48,
    parameter int                 V_ACTIVE   = 480,
    parameter int                 V_FP       = 10,
    parameter int                 V_SYNC     = 2,
    parameter int                 V_BP       = 33,
    parameter int                 PIX_DIV    = 2,
    parameter logic               SYNC_POL   = 1'b0,
    parameter int                 TILE_SHIFT = 4,
    parameter int                 BOARD_W    = 32,
    parameter int                 BOARD_H    = 30,
    parameter int                 TILE_BITS  = 4,
    parameter int                 CBITS      = 4,
    parameter logic [3*CBITS-1:0] BORDER_RGB = 12'h00F
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [TILE_BITS-1:0]                 rdata,
    input  logic                                 pal_we,
    input  logic [TILE_BITS-1:0]                 pal_idx,
    input  logic [3*CBITS-1:0]                   pal_rgb,
    output logic                                 re,
    output logic [$clog2(BOARD_W*BOARD_H)-1:0]   raddr,
    output logic [CBITS-1:0]                     R_out,
    output logic [CBITS-1:0]                     G_out,
    output logic [CBITS-1:0]                     B_out,
    output logic                                 HSync,
    output logic                                 VSync,
    output logic                                 frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int AW      = $clog2(BOARD_W * BOARD_H);
    localparam int DW      = $clog2(PIX_DIV);
    localparam int RGBW    = 3 * CBITS;
    localparam int NPAL    = 2 ** TILE_BITS;

    logic [DW-1:0]        div_q, div_d;
    logic [HCW-1:0]       hc_q, hc_d;
    logic [VCW-1:0]       vc_q, vc_d;
    logic                 re_q, re_d;
    logic                 re_dly_q, re_dly_d;
    logic [AW-1:0]        raddr_q, raddr_d;
    logic [TILE_BITS-1:0] tile_q, tile_d;
    logic                 s1_active_q, s1_active_d;
    logic                 s1_board_q, s1_board_d;
    logic                 s1_hs_q, s1_hs_d;
    logic                 s1_vs_q, s1_vs_d;
    logic                 s1_fs_q, s1_fs_d;
    logic [RGBW-1:0]      rgb_q, rgb_d;
    logic                 hs_q, hs_d;
    logic                 vs_q, vs_d;
    logic                 fs_q, fs_d;
    logic [RGBW-1:0]      pal_q [NPAL];
    logic [RGBW-1:0]      pal_d [NPAL];

    logic                 pix_en;
    logic                 active;
    logic                 in_board;
    logic                 h_sync_on;
    logic                 v_sync_on;
    logic [TILE_BITS-1:0] tile_now;

    assign pix_en = (div_q == '0);

    always_comb begin
        active    = (32'(hc_q) < H_ACTIVE) && (32'(vc_q) < V_ACTIVE);
        in_board  = ((32'(hc_q) >> TILE_SHIFT) < BOARD_W) && ((32'(vc_q) >> TILE_SHIFT) < BOARD_H);
        h_sync_on = (32'(hc_q) >= H_ACTIVE + H_FP) && (32'(hc_q) < H_ACTIVE + H_FP + H_SYNC);
        v_sync_on = (32'(vc_q) >= V_ACTIVE + V_FP) && (32'(vc_q) < V_ACTIVE + V_FP + V_SYNC);
        // rdata lands the cycle after re drops; with PIX_DIV==2 that is the stage-2 edge itself
        tile_now  = re_dly_q ? rdata : tile_q;
    end

    always_comb begin
        div_d       = (div_q == DW'(PIX_DIV - 1)) ? '0 : div_q + DW'(1);
        hc_d        = hc_q;
        vc_d        = vc_q;
        re_d        = 1'b0;
        re_dly_d    = re_q;
        raddr_d     = raddr_q;
        tile_d      = tile_now;
        s1_active_d = s1_active_q;
        s1_board_d  = s1_board_q;
        s1_hs_d     = s1_hs_q;
        s1_vs_d     = s1_vs_q;
        s1_fs_d     = s1_fs_q;
        rgb_d       = rgb_q;
        hs_d        = hs_q;
        vs_d        = vs_q;
        fs_d        = 1'b0;
        pal_d       = pal_q;
        if (pal_we) begin
            pal_d[pal_idx] = pal_rgb;
        end
        if (pix_en) begin
            if (hc_q == HCW'(H_TOTAL - 1)) begin
                hc_d = '0;
                vc_d = (vc_q == VCW'(V_TOTAL - 1)) ? '0 : vc_q + VCW'(1);
            end else begin
                hc_d = hc_q + HCW'(1);
            end
            // Stage 0: fetch request and per-pixel attributes
            if (active && in_board) begin
                re_d    = 1'b1;
                raddr_d = AW'(vc_q >> TILE_SHIFT) * AW'(BOARD_W) + AW'(hc_q >> TILE_SHIFT);
            end
            s1_active_d = active;
            s1_board_d  = active && in_board;
            s1_hs_d     = h_sync_on ? SYNC_POL : ~SYNC_POL;
            s1_vs_d     = v_sync_on ? SYNC_POL : ~SYNC_POL;
            s1_fs_d     = (hc_q == '0) && (vc_q == '0);
            // Stage 2: colour resolve, syncs move in lockstep with it
            if (s1_board_q) begin
                rgb_d = pal_q[tile_now];
            end else if (s1_active_q) begin
                rgb_d = BORDER_RGB;
            end else begin
                rgb_d = '0;
            end
            hs_d = s1_hs_q;
            vs_d = s1_vs_q;
            fs_d = s1_fs_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q       <= '0;
            hc_q        <= '0;
            vc_q        <= '0;
            re_q        <= 1'b0;
            re_dly_q    <= 1'b0;
            raddr_q     <= '0;
            tile_q      <= '0;
            s1_active_q <= 1'b0;
            s1_board_q  <= 1'b0;
            s1_hs_q     <= ~SYNC_POL;
            s1_vs_q     <= ~SYNC_POL;
            s1_fs_q     <= 1'b0;
            rgb_q       <= '0;
            hs_q        <= ~SYNC_POL;
            vs_q        <= ~SYNC_POL;
            fs_q        <= 1'b0;
            for (int i = 0; i < NPAL; i++) begin
                pal_q[i] <= (i == 1) ? '1 : '0;
            end
        end else begin
            div_q       <= div_d;
            hc_q        <= hc_d;
            vc_q        <= vc_d;
            re_q        <= re_d;
            re_dly_q    <= re_dly_d;
            raddr_q     <= raddr_d;
            tile_q      <= tile_d;
            s1_active_q <= s1_active_d;
            s1_board_q  <= s1_board_d;
            s1_hs_q     <= s1_hs_d;
            s1_vs_q     <= s1_vs_d;
            s1_fs_q     <= s1_fs_d;
            rgb_q       <= rgb_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            fs_q        <= fs_d;
            pal_q       <= pal_d;
        end
    end

    assign re          = re_q;
    assign raddr       = raddr_q;
    assign R_out       = rgb_q[3*CBITS-1:2*CBITS];
    assign G_out       = rgb_q[2*CBITS-1:CBITS];
    assign B_out       = rgb_q[CBITS-1:0];
    assign HSync       = hs_q;
    assign VSync       = vs_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_tile_engine.sv
// Bench for vga_tile_engine on a shrunken raster: random board RAM and palette writes,
// every cycle compared with a pixel-index reference model.
module tb_vga_tile_engine;
    localparam int HA = 40, HFP = 4, HSW = 6, HBP = 6;
    localparam int VA = 20, VFP = 2, VSW = 2, VBP = 3;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int PD = 3;
    localparam int TS = 2;
    localparam int BW = 8;
    localparam int BH = 4;
    localparam int TB = 4;
    localparam int CB = 4;
    localparam int AW = $clog2(BW * BH);
    localparam int FRAME = HT * VT * PD;
    localparam logic [11:0] BORDER = 12'h00F;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [TB-1:0]   rdata = '0;
    logic            pal_we = 1'b0;
    logic [TB-1:0]   pal_idx = '0;
    logic [11:0]     pal_rgb = '0;
    logic            re;
    logic [AW-1:0]   raddr;
    logic [CB-1:0]   r_out, g_out, b_out;
    logic            hsync, vsync, frame_start;

    always #5 clk = ~clk;

    vga_tile_engine #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .PIX_DIV(PD), .SYNC_POL(1'b0), .TILE_SHIFT(TS),
        .BOARD_W(BW), .BOARD_H(BH), .TILE_BITS(TB), .CBITS(CB),
        .BORDER_RGB(BORDER)
    ) dut (
        .clk(clk), .reset(rst), .rdata(rdata),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
        .re(re), .raddr(raddr),
        .R_out(r_out), .G_out(g_out), .B_out(b_out),
        .HSync(hsync), .VSync(vsync), .frame_start(frame_start)
    );

    // Board RAM: registered read, data valid the cycle after re
    logic [TB-1:0] mem [BW*BH];
    always @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: pixel n is the n-th pixel slot since reset
    logic [11:0] pal_m [16];
    logic [31:0] exp_q [$];
    int          e;
    logic        exp_re;
    logic [AW-1:0] exp_raddr;
    logic [11:0] exp_rgb;
    logic        exp_hs, exp_vs, exp_fs;

    function automatic int px_h(int n); return n % HT; endfunction
    function automatic int px_v(int n); return (n / HT) % VT; endfunction
    function automatic bit px_active(int n); return px_h(n) < HA && px_v(n) < VA; endfunction
    function automatic bit px_board(int n);
        return px_active(n) && (px_h(n) >> TS) < BW && (px_v(n) >> TS) < BH;
    endfunction
    function automatic int px_cell(int n); return (px_v(n) >> TS) * BW + (px_h(n) >> TS); endfunction
    function automatic logic [11:0] px_colour(int n);
        if (px_board(n)) return pal_m[mem[px_cell(n)]];
        if (px_active(n)) return BORDER;
        return 12'h000;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e         <= 0;
            exp_re    <= 1'b0;
            exp_raddr <= '0;
            exp_rgb   <= '0;
            exp_hs    <= 1'b1;
            exp_vs    <= 1'b1;
            exp_fs    <= 1'b0;
            exp_q.delete();
            for (int i = 0; i < 16; i++) pal_m[i] <= (i == 1) ? 12'hFFF : 12'h000;
        end else begin
            int k;
            int s;
            int p;
            k = e + 1;
            exp_re <= 1'b0;
            exp_fs <= 1'b0;
            if ((k - 1) % PD == 0) begin
                s = (k - 1) / PD;
                if (px_board(s)) begin
                    exp_re    <= 1'b1;
                    exp_raddr <= AW'(px_cell(s));
                end
                if (exp_q.size() > 0) begin
                    p = int'(exp_q.pop_front());
                    exp_rgb <= px_colour(p);
                    exp_hs  <= !(px_h(p) >= HA + HFP && px_h(p) < HA + HFP + HSW);
                    exp_vs  <= !(px_v(p) >= VA + VFP && px_v(p) < VA + VFP + VSW);
                    exp_fs  <= (px_h(p) == 0 && px_v(p) == 0);
                end
                exp_q.push_back(32'(s));
            end
            if (pal_we) pal_m[pal_idx] <= pal_rgb;
            e <= k;
        end
    end

    always @(negedge clk) begin
        check("rgb", 32'({r_out, g_out, b_out}), 32'(exp_rgb));
        check("hsync", 32'(hsync), 32'(exp_hs));
        check("vsync", 32'(vsync), 32'(exp_vs));
        check("frame_start", 32'(frame_start), 32'(exp_fs));
        check("re", 32'(re), 32'(exp_re));
        check("raddr", 32'(raddr), 32'(exp_raddr));
    end

    task automatic fill_mem();
        for (int i = 0; i < BW * BH; i++) mem[i] = TB'($urandom_range(0, 15));
    endtask

    task automatic run_clks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            pal_we  = ($urandom_range(0, 63) == 0);
            pal_idx = TB'($urandom_range(0, 15));
            pal_rgb = 12'($urandom_range(0, 4095));
        end
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        #1;
        rst    = 1'b1;
        pal_we = 1'b0;
        fill_mem();
        repeat (n) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        fill_mem();
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        run_clks(2 * FRAME + 200);
        pulse_reset(3);
        run_clks(FRAME + 300);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
